// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the bus SRAM slave: FSM state type, byte mask type, LFSR seed.
// The LFSR seed is only consumed when BUS_SRAM_RANDOM_WAIT_EN is defined.
package cpu_defs;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } BusState_t;

    typedef logic [3:0] BusMask_t;

    localparam logic [15:0] LfsrSeed = 16'hACE1;

endpackage

// File: rtl/bus_sram_wait_gen.sv
// Stall-length counter for bus_sram_slave; with BUS_SRAM_RANDOM_WAIT_EN defined a 16-bit
// Fibonacci LFSR adds 0..3 extra stall cycles to every new transaction.
module bus_sram_wait_gen
    import cpu_defs::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle_i,
    input  logic start_i,
    input  logic dec_i,
    output logic wait_done_o
);

    // The first stall cycle is spent in IDLE, so the counter holds the remaining stall cycles.
    localparam int unsigned BaseLoad = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    logic [15:0] count_q, count_d;
    logic [15:0] load_val;

`ifdef BUS_SRAM_RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign load_val = 16'(BaseLoad) + {14'd0, lfsr_q[1:0]};
`else
    assign load_val = 16'(BaseLoad);
`endif

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = load_val;
        end else if (dec_i && (count_q != 16'd0)) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // In IDLE, a zero load means the single IDLE stall cycle is the whole wait.
    assign wait_done_o = idle_i ? (load_val == 16'd0) : (count_q <= 16'd1);

endmodule

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM bus slave with fixed (or, with BUS_SRAM_RANDOM_WAIT_EN, randomised)
// wait states, byte-masked writes, sticky out-of-range flag and access counters.
module bus_sram_slave
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  BusMask_t    mask,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        stall,
    output logic        oor,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam bit          ZeroWait = (WAIT_CYCLES == 0);

    BusState_t state_q, state_d;

    logic              req;
    logic              in_range;
    logic              complete;
    logic              start;
    logic              dec;
    logic              wait_done;
    logic              we;
    logic [IdxW-1:0]   idx;
    logic              oor_q, oor_d;
    logic [31:0]       rd_count_q, rd_count_d;
    logic [31:0]       wr_count_q, wr_count_d;
    logic              unused_addr;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign req         = read | write;
    assign idx         = address[IdxW+1:2];
    assign in_range    = (address >> (IdxW + 2)) == 32'd0;
    assign unused_addr = ^address[1:0];

    bus_sram_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .idle_i      (state_q == StIdle),
        .start_i     (start),
        .dec_i       (dec),
        .wait_done_o (wait_done)
    );

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        complete = 1'b0;
        start    = 1'b0;
        dec      = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        if (ZeroWait) begin
                            complete = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            start   = 1'b1;
                            state_d = wait_done ? StDone : StWait;
                        end
                    end
                end
                StWait: begin
                    if (req) begin
                        stall = 1'b1;
                        dec   = 1'b1;
                        if (wait_done) begin
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StDone: begin
                    // A request withdrawn here is abandoned without side effects.
                    complete = req;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign we      = complete & write & in_range;
    assign data_rd = (complete && read && in_range) ? mem_q[idx] : 32'd0;

    always_comb begin
        oor_d      = oor_q | (complete & ~in_range);
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (complete) begin
            if (write) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            oor_q      <= 1'b0;
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            oor_q      <= oor_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    mem_q[idx][8*i +: 8] <= data_wr[8*i +: 8];
                end
            end
        end
    end

    assign oor      = oor_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Self-checking bench for bus_sram_slave: directed and random accesses against a word-level
// memory model; a second zero-wait instance covers back-to-back completion.
module tb_bus_sram_slave;

    localparam int unsigned Depth = 16384;
    localparam int unsigned Wait  = 1;
`ifdef BUS_SRAM_RANDOM_WAIT_EN
    localparam int StallLo = Wait;
    localparam int StallHi = Wait + 3;
`else
    localparam int StallLo = Wait;
    localparam int StallHi = Wait;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] address, data_wr, data_rd, rd_count, wr_count;
    logic        read, write, stall, oor;
    logic [3:0]  mask;

    logic [31:0] z_address, z_data_wr, z_data_rd, z_rd_count, z_wr_count;
    logic        z_read, z_write, z_stall, z_oor;
    logic [3:0]  z_mask;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [int];
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;
    logic        exp_oor = 1'b0;

    bus_sram_slave #(
        .DEPTH_WORDS (Depth),
        .WAIT_CYCLES (Wait)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .read     (read),
        .write    (write),
        .mask     (mask),
        .data_wr  (data_wr),
        .data_rd  (data_rd),
        .stall    (stall),
        .oor      (oor),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    bus_sram_slave #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0)
    ) dut_zw (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (z_address),
        .read     (z_read),
        .write    (z_write),
        .mask     (z_mask),
        .data_wr  (z_data_wr),
        .data_rd  (z_data_rd),
        .stall    (z_stall),
        .oor      (z_oor),
        .rd_count (z_rd_count),
        .wr_count (z_wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int n, input int lo, input int hi);
        checks++;
        assert (n >= lo && n <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, n, lo, hi);
        end
    endtask

    // Drives one request and holds it until the completing cycle; returns at posedge+1.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] d,
                          output logic [31:0] rdata, output int nstall);
        read = rd; write = wr; address = a; mask = m; data_wr = d;
        nstall = 0;
        rdata  = 'x;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!stall) begin
                rdata = data_rd;
                break;
            end
            nstall++;
        end
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, input string tag);
        logic [31:0] got, exp_data, w;
        int          n;
        logic        inr;
        int          wa;
        inr = (a < 32'(Depth * 4));
        wa  = int'(a >> 2);
        exp_data = 32'd0;
        if (rd && inr) exp_data = model[wa];
        access(rd, wr, a, m, d, got, n);
        chk_range({tag, " stall"}, n, StallLo, StallHi);
        chk({tag, " data_rd"}, got, exp_data);
        if (wr && inr) begin
            w = model.exists(wa) ? model[wa] : 32'hxxxx_xxxx;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) w = (w & ~(32'hFF << (8 * i))) | (d & (32'hFF << (8 * i)));
            end
            model[wa] = w;
        end
        if (wr) exp_wr++;
        else exp_rd++;
        if (!inr) exp_oor = 1'b1;
        chk({tag, " rd_count"}, rd_count, exp_rd);
        chk({tag, " wr_count"}, wr_count, exp_wr);
        chk({tag, " oor"}, 32'(oor), 32'(exp_oor));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] zexp [8];
        logic [31:0] a;
        int unsigned kind;

        rst_n = 1'b0;
        read = 1'b1; write = 1'b0; address = 32'h10; mask = 4'hF; data_wr = 32'd0;
        z_read = 1'b0; z_write = 1'b0; z_address = 32'd0; z_mask = 4'hF; z_data_wr = 32'd0;

        // Reset with a read pending: outputs must stay quiet.
        @(posedge clk);
        @(negedge clk);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst data_rd", data_rd, 32'd0);
        chk("rst oor", 32'(oor), 32'd0);
        chk("rst rd_count", rd_count, 32'd0);
        chk("rst wr_count", wr_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read  = 1'b0;
        @(posedge clk);
        #1;

        txn(1'b0, 1'b1, 32'h10, 4'hF, 32'h1234_5678, "wr10");
        txn(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, "rd10");
        txn(1'b0, 1'b1, 32'h10, 4'h5, 32'hAABB_CCDD, "wr10m5");
        txn(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, "rd10m5");
        chk("masked word", model[4], 32'h12BB_56DD);
        txn(1'b0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, "wrm0");
        txn(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, "rdm0");
        txn(1'b1, 1'b1, 32'h10, 4'hF, 32'h1111_1111, "rdwr");
        txn(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, "rdwr chk");

        txn(1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, "wr0");
        txn(1'b0, 1'b1, 32'h0001_0000, 4'hF, 32'hDEAD_BEEF, "wr oor");
        txn(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, "rd0 after oor");
        txn(1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, "rd oor");

        // Request withdrawn after the stall cycle: no update, no count.
        txn(1'b0, 1'b1, 32'h20, 4'hF, 32'h5A5A_5A5A, "wr20");
        write = 1'b1; address = 32'h20; mask = 4'hF; data_wr = 32'h0;
        @(posedge clk);
        #1;
        write = 1'b0;
        @(posedge clk);
        #1;
        chk("drop wr_count", wr_count, exp_wr);
        chk("drop rd_count", rd_count, exp_rd);
        txn(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, "rd20 after drop");

        for (int i = 0; i < 8; i++) begin
            txn(1'b0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom, "rand init");
        end
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h0001_0000 + ($urandom & 32'hFFFC);
            else a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            kind = $urandom_range(0, 2);
            txn(kind != 1, kind != 0, a, 4'($urandom), $urandom, "rand");
        end

        // Zero-wait instance: writes then back-to-back reads, never stalling.
        for (int i = 0; i < 8; i++) zexp[i] = $urandom;
        z_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            z_address = 32'(i * 4); z_data_wr = zexp[i];
            @(negedge clk);
            chk("zw wr stall", 32'(z_stall), 32'd0);
            @(posedge clk);
            #1;
        end
        z_write = 1'b0;
        z_read  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            z_address = 32'(i * 4);
            @(negedge clk);
            chk("zw rd stall", 32'(z_stall), 32'd0);
            chk("zw rd data", z_data_rd, zexp[i]);
            @(posedge clk);
            #1;
        end
        z_read = 1'b0;
        @(negedge clk);
        chk("zw rd_count", z_rd_count, 32'd8);
        chk("zw wr_count", z_wr_count, 32'd8);
        @(posedge clk);
        #1;

        // Reset during an in-flight write to 0x20 abandons it.
        write = 1'b1; address = 32'h20; mask = 4'hF; data_wr = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("inflight stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("inrst stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        write = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_oor = 1'b0;
        @(negedge clk);
        chk("post rst stall", 32'(stall), 32'd0);
        chk("post rst rd_count", rd_count, 32'd0);
        chk("post rst wr_count", wr_count, 32'd0);
        chk("post rst oor", 32'(oor), 32'd0);
        @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, "rd20 after rst");
        txn(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, "rd10 after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
